sum_display: RTL and testbench
==============================

SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit stays selected (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port sum_in, input, 5 bits, the adder result {Cout, sum4}, range 0..30.
REQ-005 The block SHALL have port load, input, 1 bit, a request to convert and display sum_in.
REQ-006 The block SHALL have port busy, output, 1 bit, high while a conversion is running.
REQ-007 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a new value is displayed.
REQ-008 The block SHALL have port bcd_out, output, 6 bits, the displayed value as {tens[1:0], units[3:0]}.
REQ-009 The block SHALL have port seg, output, 7 bits, active-low segments with seg[6:0] = g,f,e,d,c,b,a.
REQ-010 The block SHALL have port an, output, 2 bits, active-low digit enables: an[0] is units and an[1] is tens.

Function
REQ-011 The conversion FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, load=1 SHALL capture sum_in into a shift register, clear a 6-bit BCD scratch register, and go to SHIFT on the next edge.
REQ-013 SHIFT SHALL last exactly 5 cycles; each cycle SHALL add 3 to any scratch nibble >=5 and then shift the combined register left by 1 (double dabble).
REQ-014 The edge that ends the 5th SHIFT cycle SHALL load the scratch result into bcd_out and enter DONE.
REQ-015 DONE SHALL last one cycle with done=1 and SHALL then return unconditionally to IDLE.
REQ-016 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-017 Latency SHALL be fixed: with load sampled at edge N, bcd_out is updated at edge N+5 and done is high between edges N+5 and N+6.
REQ-018 load SHALL be ignored in SHIFT and DONE; sum_in SHALL be sampled only at the accepting edge.
REQ-019 bcd_out SHALL hold its value between conversions, and the display SHALL always show bcd_out.
REQ-020 sum_in values 31 and above are illegal; their bcd_out is don't-care, but the FSM SHALL still return to IDLE.
REQ-021 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the selected digit SHALL toggle.
REQ-022 an SHALL be 2'b10 while units is selected and 2'b01 while tens is selected; exactly one bit of an SHALL be low at all times.
REQ-023 seg SHALL be the standard 7-segment decode of the selected digit, e.g. 0=1000000, 1=1111001, 2=0100100, 3=0110000.
REQ-024 seg and an SHALL be registered, changing together on the same edge.
REQ-025 The refresh counter and the conversion FSM SHALL run independently; a bcd_out update SHALL NOT reset the refresh counter.

Reset
REQ-026 When rst=1, the block SHALL asynchronously force: FSM=IDLE, busy=0, done=0, bcd_out=0, refresh counter=0, units selected, an=2'b10, seg=1000000.
REQ-027 Reset during SHIFT or DONE SHALL abort the conversion, with no done pulse and bcd_out=0.
REQ-028 On the first edge after rst falls, the FSM SHALL be able to accept load.

Configuration
REQ-029 With SUM_DISPLAY_BLANK_EN defined, seg SHALL be 1111111 whenever tens is selected and tens=0 (leading-zero blanking); units SHALL never be blanked.
REQ-030 Without SUM_DISPLAY_BLANK_EN, a tens digit of 0 SHALL display 1000000; all other behaviour SHALL be identical.

Verification (REFRESH_DIV=4 in the bench)
REQ-031 Reset scenario: assert rst for 3 cycles then release -> busy=0, done=0, bcd_out=000000, an=10, seg=1000000; an toggles to 01 after 4 cycles and back after 4 more.
REQ-032 Full-scale scenario: sum_in=11110 (15+15) with a 1-cycle load -> busy high 5 cycles, done pulse at edge +5 to +6, bcd_out=110000, tens seg=0110000, units seg=1000000.
REQ-033 Sweep scenario: convert each A=B pair 0..15 (sums 0,2,...,30) -> bcd_out equals the decimal sum every time, e.g. 10 gives 010000 and 22 gives 100010.
REQ-034 Busy-load scenario: load 9, then pulse load with sum_in=20 on the 2nd SHIFT cycle -> second request ignored, bcd_out=001001, exactly one done pulse.
REQ-035 Reset-abort scenario: load 30, assert rst on the 3rd SHIFT cycle -> done never pulses, bcd_out=000000, FSM in IDLE, and the next load of 7 converts normally.
REQ-036 Blanking scenario: with SUM_DISPLAY_BLANK_EN defined, load 9 -> tens seg=1111111 and units seg=0010000; without the macro -> tens seg=1000000.

Source files
------------

// File: rtl/sum_display.sv
// Double-dabble converter for a 5-bit adder result, driving a 2-digit multiplexed 7-segment display.
// Optional leading-zero blanking of the tens digit is enabled by defining SUM_DISPLAY_BLANK_EN.
module sum_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sum_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [5:0] bcd_out,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned BIN_W     = 5;
    localparam int unsigned BCD_W     = 6;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned NUM_STEPS = 5;
    localparam int unsigned REF_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [BIN_W-1:0]   bin_q, bin_next;
    logic [BCD_W-1:0]   scratch_q, scratch_next;
    logic [STEP_W-1:0]  step_q, step_next;
    logic [BCD_W-1:0]   bcd_next;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W+BIN_W-1:0] combo;

    logic [REF_W-1:0]   ref_q, ref_next;
    logic               sel_q, sel_next;
    logic [3:0]         digit;
    logic [6:0]         seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // One double-dabble step; the 2-bit tens nibble never reaches 5, so only units is adjusted.
    always_comb begin
        adj = scratch_q;
        if (scratch_q[3:0] >= 4'd5) begin
            adj[3:0] = scratch_q[3:0] + 4'd3;
        end
        combo = {adj, bin_q} << 1;
    end

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_next   = state;
        bin_next     = bin_q;
        scratch_next = scratch_q;
        step_next    = step_q;
        bcd_next     = bcd_out;
        case (state)
            IDLE: begin
                if (load) begin
                    bin_next     = sum_in;
                    scratch_next = '0;
                    step_next    = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                bin_next     = combo[BIN_W-1:0];
                scratch_next = combo[BCD_W+BIN_W-1:BIN_W];
                step_next    = step_q + STEP_W'(1);
                if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    bcd_next   = combo[BCD_W+BIN_W-1:BIN_W];
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            step_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
        end else begin
            state     <= state_next;
            bin_q     <= bin_next;
            scratch_q <= scratch_next;
            step_q    <= step_next;
            busy      <= (state_next == SHIFT);
            done      <= (state_next == DONE);
            bcd_out   <= bcd_next;
        end
    end

    // Refresh divider and digit mux; seg is decoded from the value bcd_out takes on the same edge.
    always_comb begin
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_next = '0;
            sel_next = ~sel_q;
        end else begin
            ref_next = ref_q + REF_W'(1);
            sel_next = sel_q;
        end
        digit    = sel_next ? {2'b00, bcd_next[5:4]} : bcd_next[3:0];
        seg_next = seg_decode(digit);
`ifdef SUM_DISPLAY_BLANK_EN
        if (sel_next && (bcd_next[5:4] == 2'b00)) begin
            seg_next = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q <= '0;
            sel_q <= 1'b0;
            an    <= 2'b10;
            seg   <= 7'b1000000;
        end else begin
            ref_q <= ref_next;
            sel_q <= sel_next;
            an    <= sel_next ? 2'b01 : 2'b10;
            seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_sum_display.sv
// Randomized and directed bench for sum_display against a cycle-count based behavioural model.
module tb_sum_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sum_in;
    logic       load;
    logic       busy;
    logic       done;
    logic [5:0] bcd_out;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;

    sum_display #(.REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .sum_in  (sum_in),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0:       return int'(7'b1000000);
            1:       return int'(7'b1111001);
            2:       return int'(7'b0100100);
            3:       return int'(7'b0110000);
            4:       return int'(7'b0011001);
            5:       return int'(7'b0010010);
            6:       return int'(7'b0000010);
            7:       return int'(7'b1111000);
            8:       return int'(7'b0000000);
            9:       return int'(7'b0010000);
            default: return int'(7'b1111111);
        endcase
    endfunction

    // Model: phase 0 idle, 1..5 converting, 6 showing done; digit chosen from cycles since reset.
    int m_cyc;
    int m_phase;
    int m_pend;
    int m_bcd;
    bit m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc   <= 0;
            m_phase <= 0;
            m_bcd   <= 0;
            m_valid <= 1'b1;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_phase == 0) begin
                if (load) begin
                    m_pend  <= int'(sum_in);
                    m_phase <= 1;
                end
            end else if (m_phase == 5) begin
                m_phase <= 6;
                if (m_pend <= 30) begin
                    m_bcd   <= (m_pend / 10) * 16 + (m_pend % 10);
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (m_phase == 6) begin
                m_phase <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    bit m_tens;
    int m_seg;

    always @(negedge clk) begin
        m_tens = ((m_cyc / int'(DIV)) % 2) == 1;
        check("busy", int'(busy), int'(m_phase >= 1 && m_phase <= 5));
        check("done", int'(done), int'(m_phase == 6));
        check("an", int'(an), m_tens ? 1 : 2);
        if (m_valid) begin
            check("bcd_out", int'(bcd_out), m_bcd);
            if (m_tens) begin
`ifdef SUM_DISPLAY_BLANK_EN
                m_seg = (m_bcd / 16 == 0) ? 127 : seg_of(m_bcd / 16);
`else
                m_seg = seg_of(m_bcd / 16);
`endif
            end else begin
                m_seg = seg_of(m_bcd % 16);
            end
            check("seg", int'(seg), m_seg);
        end
    end

    task automatic convert(input int v, output int busy_cycles, output int dones);
        @(negedge clk);
        load   = 1'b1;
        sum_in = 5'(v);
        @(negedge clk);
        load   = 1'b0;
        sum_in = 5'($urandom);
        busy_cycles = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cycles++;
            if (done) dones++;
            @(negedge clk);
        end
    endtask

    task automatic wait_an(input logic [1:0] target);
        int n;
        n = 0;
        while (an != target && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_an", int'(an), int'(target));
    endtask

    int bc;
    int dc;
    int exp_v;

    initial begin
        rst    = 1'b0;
        load   = 1'b0;
        sum_in = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values and digit refresh cadence.
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bcd", int'(bcd_out), 0);
        check("rst_an", int'(an), int'(2'b10));
        check("rst_seg", int'(seg), int'(7'b1000000));
        repeat (4) @(negedge clk);
        check("refresh_an_tens", int'(an), int'(2'b01));
        repeat (4) @(negedge clk);
        check("refresh_an_units", int'(an), int'(2'b10));

        // Full scale 15+15.
        convert(30, bc, dc);
        check("fs_busy_cycles", bc, 5);
        check("fs_done_pulses", dc, 1);
        check("fs_bcd", int'(bcd_out), int'(6'b110000));
        wait_an(2'b01);
        check("fs_tens_seg", int'(seg), int'(7'b0110000));
        wait_an(2'b10);
        check("fs_units_seg", int'(seg), int'(7'b1000000));

        // Sweep of A=B sums.
        for (int i = 0; i < 16; i++) begin
            convert(2 * i, bc, dc);
            exp_v = ((2 * i) / 10) * 16 + (2 * i) % 10;
            check("sweep_bcd", int'(bcd_out), exp_v);
            check("sweep_busy_cycles", bc, 5);
            check("sweep_done_pulses", dc, 1);
            if (2 * i == 10) check("sweep_10", int'(bcd_out), int'(6'b010000));
            if (2 * i == 22) check("sweep_22", int'(bcd_out), int'(6'b100010));
        end

        // Load while busy is ignored.
        @(negedge clk);
        load = 1'b1; sum_in = 5'd9;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1; sum_in = 5'd20;
        @(negedge clk);
        load = 1'b0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        check("busyload_done_pulses", dc, 1);
        check("busyload_bcd", int'(bcd_out), int'(6'b001001));

        // Reset abort in the 3rd shift cycle.
        @(negedge clk);
        load = 1'b1; sum_in = 5'd30;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dc = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done) dc++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        check("abort_done_pulses", dc, 0);
        check("abort_bcd", int'(bcd_out), 0);
        check("abort_busy", int'(busy), 0);
        convert(7, bc, dc);
        check("abort_next_bcd", int'(bcd_out), int'(6'b000111));
        check("abort_next_done", dc, 1);

        // Leading zero handling on the tens digit.
        convert(9, bc, dc);
        wait_an(2'b01);
`ifdef SUM_DISPLAY_BLANK_EN
        check("blank_tens_seg", int'(seg), int'(7'b1111111));
`else
        check("blank_tens_seg", int'(seg), int'(7'b1000000));
`endif
        wait_an(2'b10);
        check("blank_units_seg", int'(seg), int'(7'b0010000));

        // Random loads, values (including illegal 31) and occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load   = ($urandom % 4) == 0;
            sum_in = 5'($urandom_range(0, 31));
            rst    = ($urandom % 100) == 0;
        end
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
